// File: rtl/cpu24_mem_arbiter.sv
// cpu24_mem_arbiter: shares one memory port between the CPU24 fetch (I) and data (D) requesters.
// Optional macro CPU24_ARB_RR_EN selects round-robin tie-breaking; otherwise D has fixed priority.
module cpu24_mem_arbiter #(
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 24,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_we,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              i_ack,
  output logic              i_err,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_we,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic              d_err,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mreq,
  output logic [ADDR_W-1:0] maddr,
  output logic              mwe,
  output logic [DATA_W-1:0] mwdata,
  input  logic              mack,
  input  logic [DATA_W-1:0] mrdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

`ifdef CPU24_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  localparam logic [4:0] TCNT_LAST = 5'(TIMEOUT - 1);

  state_t     r_state;
  logic       r_gnt;
  logic       r_last;
  logic       r_err;
  logic [4:0] r_tcnt;
  logic       w_any_req;
  logic       w_pick_d;

  assign w_any_req = i_req | d_req;

  // Winner selection for the IDLE grant; only a simultaneous request needs a tie-break.
  always_comb begin
    w_pick_d = d_req;
    if (i_req && d_req) begin
      w_pick_d = RR_EN ? ~r_last : 1'b1;
    end else begin
      w_pick_d = d_req;
    end
  end

  assign mreq  = (r_state == BUSY);
  assign i_ack = (r_state == DONE) && !r_gnt;
  assign d_ack = (r_state == DONE) &&  r_gnt;
  assign i_err = i_ack && r_err;
  assign d_err = d_ack && r_err;

  // Transaction FSM: grant, memory handshake with watchdog, one-cycle completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_gnt   <= 1'b0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
      r_tcnt  <= 5'd0;
      maddr   <= '0;
      mwe     <= 1'b0;
      mwdata  <= '0;
      i_rdata <= '0;
      d_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_gnt   <= w_pick_d;
            maddr   <= w_pick_d ? d_addr  : i_addr;
            mwe     <= w_pick_d ? d_we    : i_we;
            mwdata  <= w_pick_d ? d_wdata : i_wdata;
            r_tcnt  <= 5'd0;
            r_state <= BUSY;
          end else begin
            r_state <= IDLE;
          end
        end
        BUSY: begin
          if (mack) begin
            if (r_gnt) begin
              d_rdata <= mrdata;
            end else begin
              i_rdata <= mrdata;
            end
            r_err   <= 1'b0;
            r_state <= DONE;
          end else if (r_tcnt == TCNT_LAST) begin
            // Watchdog expiry: report an error with zeroed read data.
            if (r_gnt) begin
              d_rdata <= '0;
            end else begin
              i_rdata <= '0;
            end
            r_err   <= 1'b1;
            r_state <= DONE;
          end else begin
            r_tcnt <= r_tcnt + 5'd1;
          end
        end
        DONE: begin
          r_last  <= r_gnt;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu24_mem_arbiter.sv
// Scoreboard bench for cpu24_mem_arbiter: stimulus queues expected completions, a monitor
// pops and compares them whenever an ack appears; a small memory responder drives mack.
module tb_cpu24_mem_arbiter;

  typedef struct {
    logic        port;
    logic        err;
    logic        chk_rd;
    logic [23:0] rdata;
    logic [23:0] maddr;
    logic        mwe;
    logic [23:0] mwdata;
    int          nbusy;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        i_req, i_we, i_ack, i_err;
  logic [23:0] i_addr, i_wdata, i_rdata;
  logic        d_req, d_we, d_ack, d_err;
  logic [23:0] d_addr, d_wdata, d_rdata;
  logic        mreq, mwe, mack;
  logic [23:0] maddr, mwdata, mrdata;

  int          mem_wait;
  logic [23:0] mem_rd;
  logic        stray, stray_done, done;
  int          stim_tmo;
  int          bcnt;
  logic        prev_m;

  exp_t        q[$];
  exp_t        mon_e;
  int          busy_n;
  logic        prev_mreq;
  int          total, bad;

  cpu24_mem_arbiter #(.ADDR_W(24), .DATA_W(24), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_we(i_we), .i_wdata(i_wdata),
    .i_ack(i_ack), .i_err(i_err), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
    .mreq(mreq), .maddr(maddr), .mwe(mwe), .mwdata(mwdata),
    .mack(mack), .mrdata(mrdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_txn(input logic port, input logic err, input logic chk_rd,
                            input logic [23:0] rd, input logic [23:0] addr, input logic we,
                            input logic [23:0] wd, input int nb);
    exp_t e;
    e.port = port; e.err = err; e.chk_rd = chk_rd; e.rdata = rd;
    e.maddr = addr; e.mwe = we; e.mwdata = wd; e.nbusy = nb;
    q.push_back(e);
  endtask

  // Returns #1 after the edge that closes the n-th ack cycle.
  task automatic wait_acks(input int n);
    int seen;
    int cyc;
    seen = 0;
    cyc  = 0;
    while (seen < n && cyc < 60 * n) begin
      @(negedge clk);
      cyc++;
      if (i_ack || d_ack) seen++;
    end
    if (seen < n) stim_tmo++;
    @(posedge clk);
    #1;
  endtask

  // Memory responder: mack after mem_wait BUSY cycles, plus optional stray pulses.
  initial begin
    mack = 1'b0; mrdata = 24'h0; bcnt = 0; prev_m = 1'b0;
    forever begin
      @(negedge clk);
      if (mreq) begin
        mack = (bcnt == mem_wait);
        bcnt++;
      end else if (prev_m && stray_done) begin
        mack = 1'b1;
        bcnt = 0;
      end else begin
        mack = stray;
        bcnt = 0;
      end
      prev_m = mreq;
      mrdata = mem_rd;
    end
  end

  // Monitor / scoreboard.
  initial begin
    total = 0; bad = 0; busy_n = 0; prev_mreq = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("reset_ctrl", {26'd0, mreq, mwe, i_ack, d_ack, i_err, d_err}, 32'd0);
        chk("reset_maddr", {8'd0, maddr}, 32'd0);
        chk("reset_mwdata", {8'd0, mwdata}, 32'd0);
        chk("reset_i_rdata", {8'd0, i_rdata}, 32'd0);
        chk("reset_d_rdata", {8'd0, d_rdata}, 32'd0);
        busy_n = 0;
      end else begin
        if (i_ack || d_ack) begin
          chk("ack_expected", {31'd0, (q.size() != 0)}, 32'd1);
          if (q.size() != 0) begin
            mon_e = q.pop_front();
            chk("ack_port", {31'd0, d_ack}, {31'd0, mon_e.port});
            chk("ack_onehot", {31'd0, i_ack & d_ack}, 32'd0);
            chk("ack_err", {31'd0, mon_e.port ? d_err : i_err}, {31'd0, mon_e.err});
            if (mon_e.chk_rd)
              chk("ack_rdata", {8'd0, mon_e.port ? d_rdata : i_rdata}, {8'd0, mon_e.rdata});
            chk("maddr", {8'd0, maddr}, {8'd0, mon_e.maddr});
            chk("mwe", {31'd0, mwe}, {31'd0, mon_e.mwe});
            chk("mwdata", {8'd0, mwdata}, {8'd0, mon_e.mwdata});
            chk("busy_cycles", busy_n, mon_e.nbusy);
            chk("ack_after_busy", {31'd0, prev_mreq}, 32'd1);
          end
          busy_n = 0;
        end
        if (mreq) busy_n++;
      end
      prev_mreq = mreq;
      if (done) begin
        chk("queue_empty", q.size(), 32'd0);
        chk("stim_timeouts", stim_tmo, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    end
  end

  // Directed stimulus.
  initial begin
    rst = 1'b1;
    i_req = 1'b0; i_addr = 24'h0; i_we = 1'b0; i_wdata = 24'h0;
    d_req = 1'b0; d_addr = 24'h0; d_we = 1'b0; d_wdata = 24'h0;
    mem_wait = 0; mem_rd = 24'h0; stray = 1'b0; stray_done = 1'b0;
    done = 1'b0; stim_tmo = 0;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // Single zero-wait read on I.
    i_addr = 24'h000100; i_we = 1'b0; i_wdata = 24'h777777;
    mem_wait = 0; mem_rd = 24'hABCDEF;
    expect_txn(1'b0, 1'b0, 1'b1, 24'hABCDEF, 24'h000100, 1'b0, 24'h777777, 1);
    i_req = 1'b1; wait_acks(1); i_req = 1'b0;
    @(posedge clk); #1;

    // D write with 3 wait states.
    d_addr = 24'h000ABC; d_we = 1'b1; d_wdata = 24'h123456;
    mem_wait = 3; mem_rd = 24'h0F0F0F;
    expect_txn(1'b1, 1'b0, 1'b0, 24'h0, 24'h000ABC, 1'b1, 24'h123456, 4);
    d_req = 1'b1; wait_acks(1); d_req = 1'b0; d_we = 1'b0;
    @(posedge clk); #1;

    // I read that never gets mack: watchdog after 15 BUSY cycles.
    i_addr = 24'h000400; i_wdata = 24'h0;
    mem_wait = 99; mem_rd = 24'hFFFFFF;
    expect_txn(1'b0, 1'b1, 1'b1, 24'h0, 24'h000400, 1'b0, 24'h0, 15);
    i_req = 1'b1; wait_acks(1); i_req = 1'b0;

    // Stray mack in IDLE.
    @(posedge clk); #1 stray = 1'b1;
    @(posedge clk); @(posedge clk); #1 stray = 1'b0;
    @(posedge clk); #1;

    // D read with one wait state and a stray mack during DONE.
    d_addr = 24'h000500; d_wdata = 24'h0;
    mem_wait = 1; mem_rd = 24'h13579B; stray_done = 1'b1;
    expect_txn(1'b1, 1'b0, 1'b1, 24'h13579B, 24'h000500, 1'b0, 24'h0, 2);
    d_req = 1'b1; wait_acks(1); d_req = 1'b0; stray_done = 1'b0;
    @(posedge clk); #1;

    // Reset in the second BUSY cycle of a hung D access: no ack may follow.
    d_addr = 24'h000800; mem_wait = 99;
    d_req = 1'b1;
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b0;
    d_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // Both requesters held high for four back-to-back grants.
    i_addr = 24'h000600; i_we = 1'b0; i_wdata = 24'h111111;
    d_addr = 24'h000700; d_we = 1'b0; d_wdata = 24'h222222;
    mem_wait = 0; mem_rd = 24'h2468AC;
    for (int k = 0; k < 4; k++) begin
`ifdef CPU24_ARB_RR_EN
      if (k % 2 == 0)
        expect_txn(1'b1, 1'b0, 1'b1, 24'h2468AC, 24'h000700, 1'b0, 24'h222222, 1);
      else
        expect_txn(1'b0, 1'b0, 1'b1, 24'h2468AC, 24'h000600, 1'b0, 24'h111111, 1);
`else
      expect_txn(1'b1, 1'b0, 1'b1, 24'h2468AC, 24'h000700, 1'b0, 24'h222222, 1);
`endif
    end
    i_req = 1'b1; d_req = 1'b1;
    wait_acks(4);
    i_req = 1'b0; d_req = 1'b0;

    repeat (3) @(posedge clk);
    #1 done = 1'b1;
  end

endmodule
